// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// Shared byte memory arbitrated between a host port (IDLE/DONE) and a master port (SERVE).
// The run ends once RES_COUNT writes have landed in the result region.
module mem_responder #(
  parameter int unsigned DEPTH     = 6144,
  parameter int unsigned RES_BASE  = 4096,
  parameter int unsigned RES_COUNT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        en,
  input  logic        wen,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        start,
  input  logic        h_en,
  input  logic        h_wen,
  input  logic [15:0] h_addr,
  input  logic [7:0]  h_d,
  output logic [7:0]  h_q,
  input  logic        go,
  output logic        done,
  output logic        prot_err,
  output logic        range_err,
  output logic        host_err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned RES_END = RES_BASE + RES_COUNT;

  typedef enum logic [1:0] {S_IDLE, S_START, S_SERVE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         q_q, q_d;
  logic [7:0]         h_q_q, h_q_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prot_err_q, prot_err_d;
  logic               range_err_q, range_err_d;
  logic               host_err_q, host_err_d;

  logic [7:0]         mem [DEPTH];

  logic               serve_c, host_own_c, act_c, rd_c, wr_c;
  logic               in_rng_c, prot_c, res_c;
  logic [15:0]        a_c;
  logic               w_n_c;
  logic [7:0]         wd_c, rdata_c;
  logic               mem_we_c;
  logic [AW-1:0]      mem_waddr_c;
  logic [7:0]         mem_wdata_c;

  // Port selection, access classification and next-state logic.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    h_q_d       = h_q_q;
    cnt_d       = cnt_q;
    prot_err_d  = prot_err_q;
    range_err_d = range_err_q;
    host_err_d  = host_err_q;

    serve_c    = (state_q == S_SERVE);
    host_own_c = (state_q == S_IDLE) || (state_q == S_DONE);

    a_c   = serve_c ? addr : h_addr;
    w_n_c = serve_c ? wen  : h_wen;
    wd_c  = serve_c ? d    : h_d;
    act_c = serve_c ? en   : (host_own_c && h_en);

    rd_c     = act_c && w_n_c;
    wr_c     = act_c && !w_n_c;
    in_rng_c = 32'(a_c) < DEPTH;
    prot_c   = serve_c && wr_c && in_rng_c && (32'(a_c) < RES_BASE);
    mem_we_c = wr_c && in_rng_c && !prot_c;
    res_c    = serve_c && mem_we_c && (32'(a_c) >= RES_BASE) && (32'(a_c) < RES_END);

    mem_waddr_c = a_c[AW-1:0];
    mem_wdata_c = wd_c;
    rdata_c     = in_rng_c ? mem[a_c[AW-1:0]] : 8'h00;

    if (rd_c) begin
      if (serve_c) q_d   = rdata_c;
      else         h_q_d = rdata_c;
    end

    if (act_c && !in_rng_c) range_err_d = 1'b1;
    if (prot_c)             prot_err_d  = 1'b1;
    if (h_en && !host_own_c) host_err_d = 1'b1;

    if (state_q == S_START) cnt_d = '0;
    else if (res_c)         cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: state_d = S_SERVE;
      S_SERVE: if (res_c && (cnt_q == CNT_W'(RES_COUNT - 1))) state_d = S_DONE;
      S_DONE:  if (go) state_d = S_START;
      default: state_d = S_IDLE;
    endcase

    // Entering START wipes the error flags from the previous run.
    if (state_d == S_START) begin
      prot_err_d  = 1'b0;
      range_err_d = 1'b0;
      host_err_d  = 1'b0;
    end

    start_d = (state_d == S_START);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      q_q         <= 8'h00;
      h_q_q       <= 8'h00;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      prot_err_q  <= 1'b0;
      range_err_q <= 1'b0;
      host_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      h_q_q       <= h_q_d;
      start_q     <= start_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      prot_err_q  <= prot_err_d;
      range_err_q <= range_err_d;
      host_err_q  <= host_err_d;
    end
  end

  // Array has no reset so contents survive reset and successive runs.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  assign q         = q_q;
  assign h_q       = h_q_q;
  assign start     = start_q;
  assign done      = done_q;
  assign prot_err  = prot_err_q;
  assign range_err = range_err_q;
  assign host_err  = host_err_q;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for mem_responder: host access, run launch, result counting,
// protection/range/host errors and asynchronous reset with memory retention.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        en, wen;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        start;
  logic        h_en, h_wen;
  logic [15:0] h_addr;
  logic [7:0]  h_d;
  logic [7:0]  h_q;
  logic        go;
  logic        done;
  logic        prot_err, range_err, host_err;

  int total = 0;
  int bad   = 0;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .addr(addr), .en(en), .wen(wen), .d(d), .q(q), .start(start),
    .h_en(h_en), .h_wen(h_wen), .h_addr(h_addr), .h_d(h_d), .h_q(h_q),
    .go(go), .done(done),
    .prot_err(prot_err), .range_err(range_err), .host_err(host_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + (i >> 8) + 11);
  endfunction

  function automatic logic [7:0] rpat(input int i);
    return 8'(i ^ (i >> 8) ^ 8'h55);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    en = 1'b0; wen = 1'b1; addr = 16'h0; d = 8'h0;
    h_en = 1'b0; h_wen = 1'b1; h_addr = 16'h0; h_d = 8'h0;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] v);
    h_en = 1'b1; h_wen = 1'b0; h_addr = a; h_d = v;
    cycle();
    h_en = 1'b0; h_wen = 1'b1;
  endtask

  task automatic host_rd(input logic [15:0] a);
    h_en = 1'b1; h_wen = 1'b1; h_addr = a;
    cycle();
    h_en = 1'b0;
  endtask

  task automatic m_wr(input logic [15:0] a, input logic [7:0] v);
    en = 1'b1; wen = 1'b0; addr = a; d = v;
    cycle();
    en = 1'b0; wen = 1'b1;
  endtask

  task automatic m_rd(input logic [15:0] a);
    en = 1'b1; wen = 1'b1; addr = a;
    cycle();
    en = 1'b0;
  endtask

  task automatic launch();
    go = 1'b1;
    cycle();
    chk("start_pulse", 8'(start), 8'h1);
    chk("done_drops", 8'(done), 8'h0);
    chk("prot_clr", 8'(prot_err), 8'h0);
    chk("range_clr", 8'(range_err), 8'h0);
    chk("host_clr", 8'(host_err), 8'h0);
    cycle();
    go = 1'b0;
    chk("start_one_cycle", 8'(start), 8'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; go = 1'b0;
    idle_ports();
    cycle(); cycle();
    chk("rst_q", q, 8'h00);
    chk("rst_h_q", h_q, 8'h00);
    chk("rst_start", 8'(start), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_errs", 8'({prot_err, range_err, host_err}), 8'h0);
    rst_n = 1'b1;
    cycle(); cycle();
    chk("no_start_without_go", 8'(start), 8'h0);

    host_wr(16'h0010, 8'hA5);
    host_rd(16'h0010);
    chk("host_rd_a5", h_q, 8'hA5);
    cycle();
    chk("h_q_hold", h_q, 8'hA5);

    for (int i = 0; i < 4096; i++) begin
      h_en = 1'b1; h_wen = 1'b0; h_addr = 16'(i); h_d = pat(i);
      cycle();
    end
    h_en = 1'b0; h_wen = 1'b1;
    chk("h_q_hold_after_writes", h_q, 8'hA5);

    // Run 1
    launch();
    m_rd(16'h0000);
    chk("m_rd_0000", q, pat(0));
    m_rd(16'h0800);
    chk("m_rd_0800", q, pat(16'h0800));
    cycle();
    chk("q_hold", q, pat(16'h0800));

    m_wr(16'h0005, 8'hEE);
    chk("prot_err_set", 8'(prot_err), 8'h1);
    m_rd(16'h0005);
    chk("prot_old_value", q, pat(5));
    host_wr(16'h0020, 8'h77);
    chk("host_err_set", 8'(host_err), 8'h1);
    chk("host_h_q_unch", h_q, 8'hA5);

    m_rd(16'h1800);
    chk("oob_rd_zero", q, 8'h00);
    chk("range_err_set", 8'(range_err), 8'h1);

    for (int i = 0; i < 2048; i++) begin
      en = 1'b1; wen = 1'b0; addr = 16'(16'h1000 + i); d = rpat(i);
      if (i == 2047) chk("not_done_before_last", 8'(done), 8'h0);
      cycle();
    end
    en = 1'b0; wen = 1'b1;
    chk("done_after_2048", 8'(done), 8'h1);
    chk("errs_sticky", 8'({prot_err, range_err, host_err}), 8'h7);

    m_wr(16'h1000, 8'hFF);
    host_rd(16'h17FF);
    chk("host_rd_17ff", h_q, rpat(2047));
    host_rd(16'h1000);
    chk("master_ignored_done", h_q, rpat(0));
    host_rd(16'h0005);
    chk("prot_mem_intact", h_q, pat(5));
    host_rd(16'h0020);
    chk("host_wr_dropped", h_q, pat(16'h0020));
    chk("done_level", 8'(done), 8'h1);

    // Run 2: repeated writes to one result address all count
    launch();
    for (int i = 0; i < 2048; i++) begin
      en = 1'b1; wen = 1'b0; addr = 16'h1000; d = 8'h3C;
      if (i == 2047) chk("run2_not_done", 8'(done), 8'h0);
      cycle();
    end
    en = 1'b0; wen = 1'b1;
    chk("run2_done", 8'(done), 8'h1);

    // Run 3: reset asserted mid-SERVE
    launch();
    m_rd(16'h0001);
    chk("run3_rd_0001", q, pat(1));
    m_wr(16'h0005, 8'h99);
    chk("run3_prot", 8'(prot_err), 8'h1);
    rst_n = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_h_q", h_q, 8'h00);
    chk("async_done", 8'(done), 8'h0);
    chk("async_start", 8'(start), 8'h0);
    chk("async_errs", 8'({prot_err, range_err, host_err}), 8'h0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_no_start", 8'(start), 8'h0);
    host_rd(16'h17FF);
    chk("retain_17ff", h_q, rpat(2047));
    host_rd(16'h1000);
    chk("retain_1000", h_q, 8'h3C);
    host_rd(16'h0005);
    chk("retain_0005", h_q, pat(5));
    chk("host_ok_in_idle", 8'(host_err), 8'h0);

    host_rd(16'h2000);
    chk("host_oob_zero", h_q, 8'h00);
    chk("host_range_err", 8'(range_err), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
